hub75_row_sched: RTL

HUB75_ROW_SCHED -- requirements
Module: hub75_row_sched

---
 rtl/hub75_pkg.sv | 22 ++
 rtl/hub75_row_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hub75_pkg.sv
// Shared state encoding for the HUB75 row scheduler, also consumed by debug/status logic.
package hub75_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE         = 3'd0;
  localparam logic [STATE_W-1:0] ST_PREFILL      = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_PREFILL = 3'd2;
  localparam logic [STATE_W-1:0] ST_ISSUE        = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT         = 3'd4;
  localparam logic [STATE_W-1:0] ST_SWAP         = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE         = ST_IDLE,
    S_PREFILL      = ST_PREFILL,
    S_WAIT_PREFILL = ST_WAIT_PREFILL,
    S_ISSUE        = ST_ISSUE,
    S_WAIT         = ST_WAIT,
    S_SWAP         = ST_SWAP
  } sched_state_e;

endpackage

// File: rtl/hub75_row_sched.sv
// HUB75 row scheduler: ping-pong line-buffer prefetch overlapped with BCM display of the current row.
// Optional frame-swap handshake at row wrap is enabled by defining HUB75_ROW_SCHED_FSWAP_EN.
module hub75_row_sched
  import hub75_pkg::*;
#(
  parameter int unsigned N_ROWS     = 32,
  parameter int unsigned LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_run,
  output logic                  ctrl_active,
  output logic [LOG_N_ROWS-1:0] fill_row,
  output logic                  fill_buf,
  output logic                  fill_go,
  input  logic                  fill_rdy,
  output logic [LOG_N_ROWS-1:0] bcm_row,
  output logic                  bcm_row_first,
  output logic                  bcm_buf,
  output logic                  bcm_go,
  input  logic                  bcm_rdy,
  output logic                  frame_start,
  output logic                  frm_swap,
  input  logic                  frm_rdy
);

`ifdef HUB75_ROW_SCHED_FSWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
  logic unused_frm_rdy;
  assign unused_frm_rdy = frm_rdy;
`endif

  localparam logic [LOG_N_ROWS-1:0] LAST_ROW = LOG_N_ROWS'(N_ROWS - 1);

  sched_state_e          state;
  logic [LOG_N_ROWS-1:0] r;
  logic                  b;

  logic [LOG_N_ROWS-1:0] r_inc;
  logic                  at_last;
  logic                  both_rdy;
  logic                  issue;
  logic [LOG_N_ROWS-1:0] issue_row;
  logic                  issue_buf;

  assign r_inc    = LOG_N_ROWS'(r + LOG_N_ROWS'(1));
  assign at_last  = (r == LAST_ROW);
  assign both_rdy = bcm_rdy && fill_rdy;

  // Decide whether this cycle launches a display+prefetch pair, and for which row/buffer.
  always_comb begin
    issue     = 1'b0;
    issue_row = r;
    issue_buf = b;
    case (state)
      S_WAIT_PREFILL: issue = both_rdy;
      S_WAIT: begin
        issue_row = r_inc;
        issue_buf = ~b;
        issue     = both_rdy && !(at_last && (!ctrl_run || SWAP_EN));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      r             <= '0;
      b             <= 1'b0;
      ctrl_active   <= 1'b0;
      fill_row      <= '0;
      fill_buf      <= 1'b0;
      fill_go       <= 1'b0;
      bcm_row       <= '0;
      bcm_row_first <= 1'b1;
      bcm_buf       <= 1'b0;
      bcm_go        <= 1'b0;
      frame_start   <= 1'b0;
      frm_swap      <= 1'b0;
    end else begin
      fill_go     <= 1'b0;
      bcm_go      <= 1'b0;
      frame_start <= 1'b0;
      frm_swap    <= 1'b0;

      // Display row r from buffer b while the other buffer fetches row r+1.
      if (issue) begin
        bcm_go        <= 1'b1;
        bcm_row       <= issue_row;
        bcm_buf       <= issue_buf;
        bcm_row_first <= (issue_row == '0);
        frame_start   <= (issue_row == '0);
        fill_go       <= 1'b1;
        fill_row      <= LOG_N_ROWS'(issue_row + LOG_N_ROWS'(1));
        fill_buf      <= ~issue_buf;
      end

      case (state)
        S_IDLE: begin
          if (ctrl_run && fill_rdy) begin
            state       <= S_PREFILL;
            ctrl_active <= 1'b1;
            r           <= '0;
            b           <= 1'b0;
            fill_go     <= 1'b1;
            fill_row    <= '0;
            fill_buf    <= 1'b0;
          end
        end
        S_PREFILL: state <= S_WAIT_PREFILL;
        S_WAIT_PREFILL: begin
          if (both_rdy) state <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (both_rdy) begin
            r <= r_inc;
            b <= ~b;
            if (at_last && !ctrl_run) begin
              state       <= S_IDLE;
              ctrl_active <= 1'b0;
            end else if (at_last && SWAP_EN) begin
              state <= S_SWAP;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
`ifdef HUB75_ROW_SCHED_FSWAP_EN
        // Hold the scan at the frame boundary until the producer has a new frame.
        S_SWAP: begin
          if (frm_rdy && fill_rdy) begin
            state    <= S_PREFILL;
            frm_swap <= 1'b1;
            r        <= '0;
            b        <= 1'b0;
            fill_go  <= 1'b1;
            fill_row <= '0;
            fill_buf <= 1'b0;
          end
        end
`endif
        default: begin
          state       <= S_IDLE;
          ctrl_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
